icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped L1 instruction cache between FETCH and a 32-bit Avalon burst-read port.
//  Generalises the uncached line loader: line count and line size are parameters, and hits return in 1 cycle.
//  A snoop port invalidates lines hit by EXECUTE data writes, so self-modifying code stays coherent.
//  A flush input invalidates the whole cache in one cycle.
// PARAMETERS
//  ADDR_W      20   byte address width
//  LINES       64   number of lines; power of 2, >=2
//  LINE_WORDS  4    32-bit words per line (= burst length); power of 2, 2..8
// PORTS
//  clk               in   1                 clock, all logic on rising edge
//  reset_n           in   1                 asynchronous active-low reset
//  ld_addr           in   ADDR_W            fetch byte address; offset bits ignored
//  ld_req            in   1                 request toggle; pending while ld_req!=ld_ack
//  ld_ack            out  1                 toggles to ld_req when ld_data is valid
//  ld_data           out  32*LINE_WORDS     whole line, word 0 in bits [31:0]
//  ld_hit            out  1                 combinational: pending request hits a valid line
//  snp_valid         in   1                 1-cycle pulse: data write accepted at snp_addr
//  snp_addr          in   ADDR_W            snooped write byte address
//  flush             in   1                 1-cycle pulse: invalidate all lines
//  avm_address       out  ADDR_W            line-aligned burst address
//  avm_burstcount    out  4                 constant LINE_WORDS
//  avm_byteenable    out  4                 constant 4'hF
//  avm_read          out  1                 held high until accepted
//  avm_waitrequest   in   1                 slave stall
//  avm_readdatavalid in   1                 read beat valid
//  avm_readdata      in   32                read beat
//  stat_hits         out  32                hit count; see CONFIGURATION
//  stat_misses       out  32                miss count; see CONFIGURATION
// BEHAVIOUR
//  Address split: OB=log2(4*LINE_WORDS) offset, IB=log2(LINES) index, tag=ADDR_W-OB-IB upper bits.
//  Reset values: ld_ack=0, ld_data=0, avm_read=0, avm_address=0, stat_*=0.
//    All valid bits clear; state IDLE; stale=0.
//  Reset mid-fill aborts the burst. Beats arriving after reset are ignored in IDLE; memory must reset with the cache.
//  FSM: IDLE -> REQ -> FILL -> IDLE.
//  IDLE, request pending, hit: ld_data<=line; ld_ack<=ld_req next edge (latency 1); stat_hits+1.
//  IDLE, request pending, miss: latch line address; avm_read<=1; -> REQ; stat_misses+1.
//  REQ: hold avm_read and avm_address while avm_waitrequest=1.
//    First edge with waitrequest=0: avm_read<=0; beat counter<=0; -> FILL.
//  FILL: on each readdatavalid, write the beat into word[cnt] of the indexed line and cnt+1.
//    Last beat (cnt==LINE_WORDS-1), stale=0: set valid and tag; ld_data<=assembled line; ld_ack<=ld_req; -> IDLE.
//    Last beat, stale=1: discard validation; stale<=0; reissue burst (-> REQ); do not ack.
//  ld_hit is meaningful only in IDLE; it is 0 in REQ/FILL.
//  Snoop: if snp_valid and valid[snp idx] and tag matches, clear that valid bit next edge.
//    If snp_valid matches the line being filled (REQ/FILL), set stale.
//  Snoop and IDLE hit lookup on the same line in the same cycle: the lookup misses (invalidate wins).
//  flush: clear all valid bits next edge. During REQ/FILL, set stale so the current fill is refetched.
//  flush and snoop in the same cycle: flush dominates.
//  Subsequent requests are not taken until ld_ack toggles; ld_addr must be stable while pending.
// CONFIGURATION
//  ICACHE_STATS_EN defined: stat_hits/stat_misses count as above.
//    Counters wrap at 2^32 and are cleared by reset only.
//  ICACHE_STATS_EN undefined: both ports tied to 0 and no counter flops are built.
// STRUCTURE
//  cache_pkg holds:
//    typedef icache_state_t {IDLE,REQ,FILL};
//    functions ic_off_bits/ic_idx_bits/ic_tag_bits(ADDR_W,LINES,LINE_WORDS);
//    constant AVM_WORD_BYTES=4.
//  Sub-module icache_line_ram: LINES x 32*LINE_WORDS storage.
//    One async read port (index); one per-word write port (index, word sel, data).
//  Tags and valid bits stay in icache_dm as flops so flush clears them in one cycle.
// TESTING
//  1 Cold miss: ld_addr=0x01230, toggle ld_req.
//    -> one burst, avm_address=0x01230, burstcount=4; 4 beats A0..A3.
//    -> ld_ack toggles 1 cycle after last beat; ld_data={A3,A2,A1,A0}; stat_misses=1.
//  2 Re-fetch 0x0123C.
//    -> ld_hit=1, no avm_read, ld_ack toggles after 1 cycle, same data; stat_hits=1.
//  3 Snoop write 0x01234, then fetch 0x01230 -> miss, new burst issued.
//    Snoop 0x41230 (other tag) -> line stays valid.
//  4 Snoop 0x01238 during FILL of line 0x01230, after beat 1.
//    -> second burst at 0x01230; ack carries second burst data only.
//  5 Hold waitrequest=1 for 5 cycles -> avm_read/address stable; fill completes normally.
//    Assert reset_n=0 after beat 2 -> outputs at reset values; next fetch misses.
//  6 flush after filling lines 0 and 63 -> both miss on re-fetch.
//    Alias 0x00000 vs 0x00400 (LINES=64) -> evicts, second fetch of 0x00000 misses.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared types, constants and address-split helpers for the
//               direct-mapped instruction cache (icache_dm).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents
//   icache_state_t  controller state (IDLE, REQ, FILL)
//   AVM_WORD_BYTES  bytes per Avalon data beat
//   ic_off_bits     byte-offset width of a line
//   ic_idx_bits     line-index width
//   ic_tag_bits     tag width
// ============================================================================
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } icache_state_t;

  localparam int AVM_WORD_BYTES = 4;

  function automatic int ic_off_bits(input int line_words);
    return $clog2(AVM_WORD_BYTES * line_words);
  endfunction

  function automatic int ic_idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int ic_tag_bits(input int addr_w, input int lines, input int line_words);
    return addr_w - ic_off_bits(line_words) - ic_idx_bits(lines);
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_ram
// Description : Line storage for icache_dm. LINES entries of LINE_WORDS
//               32-bit words. Asynchronous whole-line read, per-word write.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock (write port)
//   rd_idx_i   in   read line index
//   rd_data_o  out  read line, word 0 in the low bits
//   we_i       in   write enable
//   wr_idx_i   in   write line index
//   wr_sel_i   in   word within the line being written
//   wr_data_i  in   write word
// ============================================================================
module icache_line_ram
  import cache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                                          clk,
  input  logic [$clog2(LINES)-1:0]                      rd_idx_i,
  output logic [AVM_WORD_BYTES*8*LINE_WORDS-1:0]        rd_data_o,
  input  logic                                          we_i,
  input  logic [$clog2(LINES)-1:0]                      wr_idx_i,
  input  logic [$clog2(LINE_WORDS)-1:0]                 wr_sel_i,
  input  logic [AVM_WORD_BYTES*8-1:0]                   wr_data_i
);

  localparam int WORD_W = AVM_WORD_BYTES * 8;
  localparam int LINE_W = WORD_W * LINE_WORDS;

  logic [LINE_W-1:0] mem_q [LINES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_idx_i][int'(wr_sel_i)*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : icache_dm
// Description : Direct-mapped L1 instruction cache between FETCH and a
//               32-bit Avalon burst-read port. 1-cycle hits, whole-line
//               refill bursts, write-snoop invalidation and 1-cycle flush.
// Revision    : 1.0  initial release
// Config macro: ICACHE_STATS_EN - when defined, stat_hits/stat_misses count
//               lookups; when undefined both are tied to 0.
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   ld_addr/ld_req           fetch line request (toggle handshake)
//   ld_ack/ld_data           response toggle and whole line
//   ld_hit                   pending request hits a valid line (IDLE only)
//   snp_valid/snp_addr       snooped data write, invalidates a matching line
//   flush                    invalidate every line
//   avm_*                    Avalon-MM burst read master
//   stat_hits/stat_misses    lookup statistics
// ============================================================================
module icache_dm
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic                       ld_req,
  output logic                       ld_ack,
  output logic [32*LINE_WORDS-1:0]   ld_data,
  output logic                       ld_hit,
  input  logic                       snp_valid,
  input  logic [ADDR_W-1:0]          snp_addr,
  input  logic                       flush,
  output logic [ADDR_W-1:0]          avm_address,
  output logic [3:0]                 avm_burstcount,
  output logic [3:0]                 avm_byteenable,
  output logic                       avm_read,
  input  logic                       avm_waitrequest,
  input  logic                       avm_readdatavalid,
  input  logic [31:0]                avm_readdata,
  output logic [31:0]                stat_hits,
  output logic [31:0]                stat_misses
);

  localparam int OB     = ic_off_bits(LINE_WORDS);
  localparam int IB     = ic_idx_bits(LINES);
  localparam int TB     = ic_tag_bits(ADDR_W, LINES, LINE_WORDS);
  localparam int LA_W   = ADDR_W - OB;
  localparam int WORD_W = AVM_WORD_BYTES * 8;
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int CB     = $clog2(LINE_WORDS);
  localparam logic [CB-1:0] LAST_CNT = CB'(LINE_WORDS - 1);

  icache_state_t     state_q;
  logic [LINES-1:0]  valid_q;
  logic [TB-1:0]     tag_q [LINES];
  logic              stale_q;
  logic [LA_W-1:0]   line_q;
  logic [CB-1:0]     cnt_q;
  logic              ld_ack_q;
  logic [LINE_W-1:0] ld_data_q;
  logic              avm_read_q;

  logic [LA_W-1:0]   w_req_line, w_snp_line;
  logic [IB-1:0]     w_req_idx, w_snp_idx, w_fill_idx, w_rd_idx;
  logic [TB-1:0]     w_req_tag, w_snp_tag;
  logic              w_pending, w_hit, w_snp_kill, w_snp_inval, w_snp_fill;
  logic              w_stale, w_last, w_fill_ok, w_we;
  logic [LINE_W-1:0] w_rd_line, w_fill_line;

  assign w_req_line = ld_addr[ADDR_W-1:OB];
  assign w_snp_line = snp_addr[ADDR_W-1:OB];
  assign w_req_idx  = w_req_line[IB-1:0];
  assign w_snp_idx  = w_snp_line[IB-1:0];
  assign w_fill_idx = line_q[IB-1:0];
  assign w_req_tag  = w_req_line[LA_W-1 -: TB];
  assign w_snp_tag  = w_snp_line[LA_W-1 -: TB];

  assign w_pending  = ld_req ^ ld_ack_q;

  // A snoop or flush landing on the looked-up line in the same cycle must win
  // over the hit, otherwise stale code could be returned.
  assign w_snp_kill  = snp_valid && (w_snp_line == w_req_line);
  assign w_hit       = (state_q == IDLE) && w_pending && valid_q[w_req_idx] &&
                       (tag_q[w_req_idx] == w_req_tag) && !w_snp_kill && !flush;
  assign w_snp_inval = snp_valid && valid_q[w_snp_idx] && (tag_q[w_snp_idx] == w_snp_tag);

  // Stale includes an invalidation arriving in this very cycle so that a
  // snoop coinciding with the last beat still forces a refetch.
  assign w_snp_fill  = snp_valid && (w_snp_line == line_q);
  assign w_stale     = stale_q || ((state_q != IDLE) && (flush || w_snp_fill));

  assign w_we      = (state_q == FILL) && avm_readdatavalid;
  assign w_last    = w_we && (cnt_q == LAST_CNT);
  assign w_fill_ok = w_last && !w_stale;
  assign w_rd_idx  = (state_q == IDLE) ? w_req_idx : w_fill_idx;

  icache_line_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_ram (
    .clk       (clk),
    .rd_idx_i  (w_rd_idx),
    .rd_data_o (w_rd_line),
    .we_i      (w_we),
    .wr_idx_i  (w_fill_idx),
    .wr_sel_i  (cnt_q),
    .wr_data_i (avm_readdata)
  );

  // The RAM write of the final beat lands on the same edge as the response,
  // so the returned line is the stored words with the final beat merged in.
  always_comb begin
    w_fill_line = w_rd_line;
    w_fill_line[int'(cnt_q)*WORD_W +: WORD_W] = avm_readdata;
  end

  always_ff @(posedge clk) begin
    if (w_fill_ok) begin
      tag_q[w_fill_idx] <= line_q[LA_W-1 -: TB];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      stale_q    <= 1'b0;
      line_q     <= '0;
      cnt_q      <= '0;
      ld_ack_q   <= 1'b0;
      ld_data_q  <= '0;
      avm_read_q <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else begin
        if (w_snp_inval) valid_q[w_snp_idx] <= 1'b0;
        if (w_fill_ok)   valid_q[w_fill_idx] <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (w_pending) begin
            if (w_hit) begin
              ld_data_q <= w_rd_line;
              ld_ack_q  <= ld_req;
            end else begin
              line_q     <= w_req_line;
              avm_read_q <= 1'b1;
              stale_q    <= 1'b0;
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (w_stale) stale_q <= 1'b1;
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (w_stale) stale_q <= 1'b1;
          if (avm_readdatavalid) begin
            cnt_q <= cnt_q + 1'b1;
            if (w_last) begin
              if (w_stale) begin
                stale_q    <= 1'b0;
                avm_read_q <= 1'b1;
                state_q    <= REQ;
              end else begin
                ld_data_q <= w_fill_line;
                ld_ack_q  <= ld_req;
                state_q   <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ld_ack         = ld_ack_q;
  assign ld_data        = ld_data_q;
  assign ld_hit         = w_hit;
  assign avm_read       = avm_read_q;
  assign avm_address    = {line_q, {OB{1'b0}}};
  assign avm_burstcount = 4'(LINE_WORDS);
  assign avm_byteenable = 4'hF;

`ifdef ICACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if ((state_q == IDLE) && w_pending) begin
      if (w_hit) hits_q   <= hits_q + 32'd1;
      else       misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

  // Byte-offset bits select nothing inside a whole-line cache.
  logic unused_offset;
  assign unused_offset = ^{ld_addr[OB-1:0], snp_addr[OB-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_dm
// Description : Self-checking bench for icache_dm (default parameters).
//               Directed scenarios followed by randomized fetch/snoop/flush
//               traffic against a line-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_icache_dm;

  localparam int ADDR_W = 20;
  localparam int LINES  = 64;
  localparam int LW     = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              ld_req = 1'b0;
  logic              ld_ack;
  logic [32*LW-1:0]  ld_data;
  logic              ld_hit;
  logic              snp_valid = 1'b0;
  logic [ADDR_W-1:0] snp_addr = '0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_burstcount;
  logic [3:0]        avm_byteenable;
  logic              avm_read;
  logic              avm_waitrequest = 1'b0;
  logic              avm_readdatavalid = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;

  always #5 clk = ~clk;

  icache_dm #(.ADDR_W(ADDR_W), .LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ld_addr           (ld_addr),
    .ld_req            (ld_req),
    .ld_ack            (ld_ack),
    .ld_data           (ld_data),
    .ld_hit            (ld_hit),
    .snp_valid         (snp_valid),
    .snp_addr          (snp_addr),
    .flush             (flush),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .stat_hits         (stat_hits),
    .stat_misses       (stat_misses)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: what each cache line holds, in plain line terms.
  bit           m_valid [LINES];
  int           m_tag   [LINES];
  logic [127:0] m_data  [LINES];
  int           m_hits = 0;
  int           m_misses = 0;

  function automatic int line_of(input int a); return a / 16;             endfunction
  function automatic int idx_of (input int a); return (a / 16) % LINES;   endfunction
  function automatic int tag_of (input int a); return a / (16 * LINES);   endfunction

  function automatic int pool_addr();
    return int'($urandom_range(0, 3)) * 1024 + int'($urandom_range(0, 7)) * 16 +
           int'($urandom_range(0, 15));
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_snoop(input int a);
    if (m_valid[idx_of(a)] && m_tag[idx_of(a)] == tag_of(a)) m_valid[idx_of(a)] = 1'b0;
  endtask

  task automatic model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check_eq({tag, "_hits"}, stat_hits, m_hits);
    check_eq({tag, "_misses"}, stat_misses, m_misses);
`else
    check_eq({tag, "_hits"}, stat_hits, 0);
    check_eq({tag, "_misses"}, stat_misses, 0);
`endif
  endtask

  task automatic do_snoop(input int a);
    @(negedge clk);
    snp_valid = 1'b1; snp_addr = ADDR_W'(a);
    model_snoop(a);
    @(negedge clk);
    snp_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Acts as the Avalon slave for one burst; called at the negedge right after
  // the cache should have raised avm_read.
  task automatic serve(input int line_addr, input int wait_cyc, input int inj_beat,
                       input bit inj_flush, input int inj_addr, output logic [127:0] data);
    logic [31:0] w;
    check_eq("avm_read_up", avm_read, 1'b1);
    check_eq("avm_address", avm_address, ADDR_W'(line_addr));
    check_eq("avm_burstcount", avm_burstcount, 4'd4);
    check_eq("avm_byteenable", avm_byteenable, 4'hF);
    check_eq("ld_hit_busy", ld_hit, 1'b0);
    for (int i = 0; i < wait_cyc; i++) begin
      avm_waitrequest = 1'b1;
      @(negedge clk);
      check_eq("avm_read_hold", avm_read, 1'b1);
      check_eq("avm_address_hold", avm_address, ADDR_W'(line_addr));
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check_eq("avm_read_drop", avm_read, 1'b0);
    data = '0;
    for (int b = 0; b < LW; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = $urandom;
      data[b*32 +: 32] = w;
      avm_readdatavalid = 1'b1;
      avm_readdata = w;
      if (b == inj_beat) begin
        if (inj_flush) begin
          flush = 1'b1;
          model_flush();
        end else begin
          snp_valid = 1'b1; snp_addr = ADDR_W'(inj_addr);
          model_snoop(inj_addr);
        end
      end
      @(negedge clk);
      avm_readdatavalid = 1'b0; flush = 1'b0; snp_valid = 1'b0;
    end
  endtask

  // One fetch transaction. csnp: snoop csnp_addr in the request cycle.
  // inj_beat (0..LW-2, or -1): snoop inj_addr / flush during that fill beat.
  task automatic fetch(input int addr, input bit csnp, input int csnp_addr, input int wait_cyc,
                       input int inj_beat, input bit inj_flush, input int inj_addr);
    int           ix, tg, base;
    bit           exp_hit, stale;
    logic [127:0] d;
    ix = idx_of(addr); tg = tag_of(addr); base = line_of(addr) * 16;
    @(negedge clk);
    ld_addr = ADDR_W'(addr);
    ld_req  = !ld_req;
    if (csnp) begin snp_valid = 1'b1; snp_addr = ADDR_W'(csnp_addr); end
    exp_hit = m_valid[ix] && (m_tag[ix] == tg) && !(csnp && line_of(csnp_addr) == line_of(addr));
    #1 check_eq("ld_hit", ld_hit, exp_hit);
    if (csnp) model_snoop(csnp_addr);
    @(negedge clk);
    snp_valid = 1'b0;
    if (exp_hit) begin
      m_hits++;
      check_eq("hit_ack", ld_ack, ld_req);
      check_eq("hit_data", ld_data, m_data[ix]);
      check_eq("hit_no_read", avm_read, 1'b0);
    end else begin
      m_misses++;
      stale = (inj_beat >= 0) && (inj_beat < LW - 1) &&
              (inj_flush || line_of(inj_addr) == line_of(addr));
      serve(base, wait_cyc, inj_beat, inj_flush, inj_addr, d);
      if (stale) begin
        check_eq("stale_no_ack", ld_ack, !ld_req);
        serve(base, 0, -1, 1'b0, 0, d);
      end
      check_eq("miss_ack", ld_ack, ld_req);
      check_eq("miss_data", ld_data, d);
      m_valid[ix] = 1'b1; m_tag[ix] = tg; m_data[ix] = d;
    end
  endtask

  initial begin
    int a, k, ib, ia;
    bit cs, fl;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_ld_ack", ld_ack, 1'b0);
    check_eq("rst_ld_data", ld_data, '0);
    check_eq("rst_avm_read", avm_read, 1'b0);
    check_eq("rst_avm_address", avm_address, '0);
    check_stats("rst");
    reset_n = 1'b1;

    // Cold miss, then hit on the same line
    fetch(32'h01230, 1'b0, 0, 0, -1, 1'b0, 0);
    check_stats("cold");
    fetch(32'h0123C, 1'b0, 0, 0, -1, 1'b0, 0);
    check_stats("rehit");

    // Snoop invalidation, and a snoop to another tag leaves the line alone
    do_snoop(32'h01234);
    fetch(32'h01230, 1'b0, 0, 0, -1, 1'b0, 0);
    do_snoop(32'h41230);
    fetch(32'h01230, 1'b0, 0, 0, -1, 1'b0, 0);

    // Snoop of the line under refill forces a second burst
    do_snoop(32'h01230);
    fetch(32'h01230, 1'b0, 0, 1, 1, 1'b0, 32'h01238);
    // Flush during refill also forces a second burst
    fetch(32'h00800, 1'b0, 0, 0, 0, 1'b1, 0);

    // Long waitrequest stall
    fetch(32'h02340, 1'b0, 0, 5, -1, 1'b0, 0);

    // Reset in the middle of a fill
    @(negedge clk);
    ld_addr = 20'h05670; ld_req = !ld_req;
    @(negedge clk);
    check_eq("mid_avm_read", avm_read, 1'b1);
    @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      avm_readdatavalid = 1'b1; avm_readdata = $urandom;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
    end
    reset_n = 1'b0; ld_req = 1'b0;
    model_flush(); m_hits = 0; m_misses = 0;
    #1;
    check_eq("mid_rst_ld_ack", ld_ack, 1'b0);
    check_eq("mid_rst_ld_data", ld_data, '0);
    check_eq("mid_rst_avm_read", avm_read, 1'b0);
    check_eq("mid_rst_avm_address", avm_address, '0);
    check_stats("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    // A stray beat in IDLE must be ignored
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    check_eq("stray_no_ack", ld_ack, 1'b0);
    check_eq("stray_no_read", avm_read, 1'b0);
    fetch(32'h05670, 1'b0, 0, 0, -1, 1'b0, 0);

    // Flush after filling the first and last lines; index aliasing
    fetch(32'h00000, 1'b0, 0, 0, -1, 1'b0, 0);
    fetch(32'h003F0, 1'b0, 0, 0, -1, 1'b0, 0);
    do_flush();
    fetch(32'h00000, 1'b0, 0, 0, -1, 1'b0, 0);
    fetch(32'h003F0, 1'b0, 0, 0, -1, 1'b0, 0);
    fetch(32'h00400, 1'b0, 0, 0, -1, 1'b0, 0);
    fetch(32'h00000, 1'b0, 0, 0, -1, 1'b0, 0);
    check_stats("directed");

    // Randomized traffic over a small address pool (4 tags x 8 lines)
    for (int it = 0; it < 250; it++) begin
      a = pool_addr();
      k = int'($urandom_range(0, 99));
      if (k < 12) begin
        do_snoop(($urandom_range(0, 1) == 0) ? pool_addr() : line_of(a) * 16 + 8);
      end else if (k < 16) begin
        do_flush();
      end else begin
        cs = ($urandom_range(0, 9) == 0);
        ib = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, LW - 2)) : -1;
        fl = ($urandom_range(0, 4) == 0);
        ia = ($urandom_range(0, 1) == 0) ? line_of(a) * 16 + int'($urandom_range(0, 15)) : pool_addr();
        fetch(a, cs, ($urandom_range(0, 1) == 0) ? a : pool_addr(),
              int'($urandom_range(0, 3)), ib, fl, ia);
      end
      if (it % 50 == 49) check_stats("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
